// File: rtl/knight_link_pkg.sv
// Shared types and constants for the remote-commander serial link.
// Pure declarations; no timing or flow control of its own.
package knight_link_pkg;

  typedef enum logic {RX_IDLE, RX_RECV} rx_state_t;
  typedef enum logic {TX_IDLE, TX_XMIT} tx_state_t;
  typedef enum logic {ASM_HIGH, ASM_LOW} asm_state_t;

  localparam logic [7:0] ACK_POS = 8'hA5;
  localparam logic [7:0] ACK_NEG = 8'hEE;

  localparam int BAUD_DIV_DEF  = 5208;
  localparam int BAUD_DIV_FAST = 16;

  // Baud counter width: one spare bit so BAUD_DIV itself always fits.
  function automatic int baud_cnt_w(input int div);
    return $clog2(div) + 1;
  endfunction

endpackage

// File: rtl/knight_uart_rx.sv
// 8N1 receiver: sync, start detect, mid-bit sampler; byte/frm_err pulse ~BAUD_DIV/2+4 clk after stop start.
// No backpressure: o_rx_rdy is a single-cycle pulse and must be taken when it fires.
module knight_uart_rx
  import knight_link_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEF
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx,
  output logic [7:0] o_rx_byte,
  output logic       o_rx_rdy,
  output logic       o_frm_err
);

  localparam int CNT_W = baud_cnt_w(BAUD_DIV);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(BAUD_DIV / 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_prev;
  rx_state_t        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_bit;
  logic [7:0]       r_shift;
  logic [7:0]       r_byte;
  logic             r_rdy;
  logic             r_frm;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
      r_state <= RX_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_byte  <= '0;
      r_rdy   <= 1'b0;
      r_frm   <= 1'b0;
    end else begin
      r_sync1 <= i_rx;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_rdy   <= 1'b0;
      r_frm   <= 1'b0;
      case (r_state)
        RX_IDLE: begin
          if (r_prev && !r_sync2) begin
            r_state <= RX_RECV;
            r_cnt   <= CNT_HALF;
            r_bit   <= '0;
          end
        end
        RX_RECV: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_ONE;
          end else begin
            r_cnt <= CNT_FULL;
            r_bit <= r_bit + 4'd1;
            if (r_bit == 4'd0) begin
              // A start bit that is high again at mid-bit was only a glitch.
              if (r_sync2) r_state <= RX_IDLE;
            end else if (r_bit == 4'd9) begin
              r_state <= RX_IDLE;
              if (r_sync2) begin
                r_byte <= r_shift;
                r_rdy  <= 1'b1;
              end else begin
                r_frm  <= 1'b1;
              end
            end else begin
              r_shift <= {r_sync2, r_shift[7:1]};
            end
          end
        end
        default: r_state <= RX_IDLE;
      endcase
    end
  end

  assign o_rx_byte = r_byte;
  assign o_rx_rdy  = r_rdy;
  assign o_frm_err = r_frm;

endmodule

// File: rtl/knight_cmd_link.sv
// Command link: two RX bytes (high first) -> 16-bit cmd with cmd_rdy; 8N1 response byte out on TX.
// cmd_rdy set 1 clk after the low byte's stop sample; trmt while busy is dropped, no queueing.
module knight_cmd_link
  import knight_link_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RX,
  output logic        TX,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        trmt,
  output logic        tx_done,
  output logic        frm_err
);

  localparam int CNT_W = baud_cnt_w(BAUD_DIV);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [7:0] w_rx_byte;
  logic       w_rx_rdy;
  logic       w_frm_err;

  knight_uart_rx #(
    .BAUD_DIV (BAUD_DIV)
  ) u_rx (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_rx      (RX),
    .o_rx_byte (w_rx_byte),
    .o_rx_rdy  (w_rx_rdy),
    .o_frm_err (w_frm_err)
  );

  asm_state_t  r_asm;
  logic [15:0] r_cmd;
  logic        r_cmd_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_asm     <= ASM_HIGH;
      r_cmd     <= '0;
      r_cmd_rdy <= 1'b0;
    end else begin
      // Default clear first so a same-cycle set below overrides it.
      if (clr_cmd_rdy) r_cmd_rdy <= 1'b0;
      case (r_asm)
        ASM_HIGH: begin
          if (w_rx_rdy) begin
            r_cmd[15:8] <= w_rx_byte;
            r_cmd_rdy   <= 1'b0;
            r_asm       <= ASM_LOW;
          end
        end
        ASM_LOW: begin
          if (w_rx_rdy) begin
            r_cmd[7:0] <= w_rx_byte;
            r_cmd_rdy  <= 1'b1;
            r_asm      <= ASM_HIGH;
          end else if (w_frm_err) begin
            r_asm <= ASM_HIGH;
          end
        end
        default: r_asm <= ASM_HIGH;
      endcase
    end
  end

  tx_state_t        r_tx_state;
  logic [9:0]       r_tx_shift;
  logic [CNT_W-1:0] r_tx_cnt;
  logic [3:0]       r_tx_bit;
  logic             r_tx_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_state <= TX_IDLE;
      r_tx_shift <= '1;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_done  <= 1'b0;
    end else begin
      case (r_tx_state)
        TX_IDLE: begin
          if (trmt) begin
            r_tx_shift <= {1'b1, resp, 1'b0};
            r_tx_cnt   <= CNT_FULL;
            r_tx_bit   <= '0;
            r_tx_done  <= 1'b0;
            r_tx_state <= TX_XMIT;
          end
        end
        TX_XMIT: begin
          if (r_tx_cnt != '0) begin
            r_tx_cnt <= r_tx_cnt - CNT_ONE;
          end else if (r_tx_bit == 4'd9) begin
            r_tx_done  <= 1'b1;
            r_tx_state <= TX_IDLE;
          end else begin
            // Ones shift in behind the frame so the line idles high afterwards.
            r_tx_shift <= {1'b1, r_tx_shift[9:1]};
            r_tx_cnt   <= CNT_FULL;
            r_tx_bit   <= r_tx_bit + 4'd1;
          end
        end
        default: r_tx_state <= TX_IDLE;
      endcase
    end
  end

  assign TX      = r_tx_shift[0];
  assign cmd     = r_cmd;
  assign cmd_rdy = r_cmd_rdy;
  assign tx_done = r_tx_done;
  assign frm_err = w_frm_err;

endmodule
